// File: rtl/ysyx_25060173_alu_arb.sv
// Two-requester arbiter in front of a shared combinational ALU.
// Grants one operation per cycle and holds each requester's result until it is consumed.
module ysyx_25060173_alu_arb #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_src1,
  input  logic [31:0] req0_src2,
  input  logic [12:0] req0_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_src1,
  input  logic [31:0] req1_src2,
  input  logic [12:0] req1_op,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [12:0] alu_op,
  input  logic [31:0] alu_result
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 13;

  logic elig0;
  logic elig1;
  logic grant0;
  logic grant1;
  logic ptr;
  logic ptr_nxt;

  // A requester may issue only if its response slot is free or draining this cycle.
  always_comb begin
    elig0  = req0_valid & (~rsp0_valid | rsp0_ready) & ~rst;
    elig1  = req1_valid & (~rsp1_valid | rsp1_ready) & ~rst;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (FIXED_PRIO != 0) begin
      grant0 = elig0;
      grant1 = elig1 & ~elig0;
    end else if (elig0 && elig1) begin
      grant0 = ~ptr;
      grant1 = ptr;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Pointer moves to the requester that just lost the turn.
  always_comb begin
    ptr_nxt = ptr;
    if (grant0) begin
      ptr_nxt = 1'b1;
    end else if (grant1) begin
      ptr_nxt = 1'b0;
    end
  end

  // Shared ALU operand mux; idle cycles present zeros.
  always_comb begin
    alu_src1 = XLEN'(0);
    alu_src2 = XLEN'(0);
    alu_op   = OPW'(0);
    if (grant0) begin
      alu_src1 = req0_src1;
      alu_src2 = req0_src2;
      alu_op   = req0_op;
    end else if (grant1) begin
      alu_src1 = req1_src1;
      alu_src2 = req1_src2;
      alu_op   = req1_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_result <= XLEN'(0);
      rsp1_result <= XLEN'(0);
    end else begin
      ptr <= ptr_nxt;
      if (grant0) begin
        rsp0_valid  <= 1'b1;
        rsp0_result <= alu_result;
      end else if (rsp0_ready) begin
        rsp0_valid  <= 1'b0;
      end
      if (grant1) begin
        rsp1_valid  <= 1'b1;
        rsp1_result <= alu_result;
      end else if (rsp1_ready) begin
        rsp1_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25060173_alu_arb.sv
// Bench for ysyx_25060173_alu_arb: round-robin and fixed-priority instances share stimulus
// and are checked each cycle against a behavioural arbiter/ALU model.
module tb_ysyx_25060173_alu_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid [2];
  logic [31:0] req_src1  [2];
  logic [31:0] req_src2  [2];
  logic [12:0] req_op    [2];
  logic        rsp_ready [2];

  logic [1:0]  obs_rdy   [2];
  logic [1:0]  obs_rv    [2];
  logic [31:0] obs_res0  [2];
  logic [31:0] obs_res1  [2];
  logic [31:0] obs_as1   [2];
  logic [31:0] obs_as2   [2];
  logic [12:0] obs_aop   [2];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [12:0] op);
    case (op)
      13'h0004: alu_fn = a + b;
      13'h0008: alu_fn = a - b;
      13'h0010: alu_fn = a & b;
      13'h0800: alu_fn = {31'b0, a < b};
      13'h1000: alu_fn = a << b[4:0];
      default:  alu_fn = a ^ b ^ {19'b0, op};
    endcase
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_dut
    logic r0, r1, v0, v1;
    logic [31:0] res0, res1, as1, as2, ar;
    logic [12:0] aop;
    assign ar = alu_fn(as1, as2, aop);
    ysyx_25060173_alu_arb #(.FIXED_PRIO(d)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(req_valid[0]), .req0_ready(r0), .req0_src1(req_src1[0]),
      .req0_src2(req_src2[0]), .req0_op(req_op[0]),
      .rsp0_valid(v0), .rsp0_ready(rsp_ready[0]), .rsp0_result(res0),
      .req1_valid(req_valid[1]), .req1_ready(r1), .req1_src1(req_src1[1]),
      .req1_src2(req_src2[1]), .req1_op(req_op[1]),
      .rsp1_valid(v1), .rsp1_ready(rsp_ready[1]), .rsp1_result(res1),
      .alu_src1(as1), .alu_src2(as2), .alu_op(aop), .alu_result(ar)
    );
    assign obs_rdy[d]  = {r1, r0};
    assign obs_rv[d]   = {v1, v0};
    assign obs_res0[d] = res0;
    assign obs_res1[d] = res1;
    assign obs_as1[d]  = as1;
    assign obs_as2[d]  = as2;
    assign obs_aop[d]  = aop;
  end

  // Reference state: next-turn requester, pending-response flags and stored results.
  int          m_turn [2];
  logic [1:0]  m_rv   [2];
  logic [31:0] m_res  [2][2];
  int          last_win [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check both instances mid-cycle, advance the model, then move past the next rising edge.
  task automatic cycle();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      bit          ok [2];
      int          win;
      int          pref;
      logic [1:0]  exp_rdy;
      for (int i = 0; i < 2; i++)
        ok[i] = !rst && req_valid[i] && (!m_rv[d][i] || rsp_ready[i]);
      pref = (d == 1) ? 0 : m_turn[d];
      if (ok[pref])          win = pref;
      else if (ok[1 - pref]) win = 1 - pref;
      else                   win = -1;
      exp_rdy = (win < 0) ? 2'b00 : ((win == 0) ? 2'b01 : 2'b10);

      check($sformatf("d%0d ready", d), 32'(obs_rdy[d]), 32'(exp_rdy));
      check($sformatf("d%0d rsp_valid", d), 32'(obs_rv[d]), 32'(m_rv[d]));
      check($sformatf("d%0d rsp0_result", d), obs_res0[d], m_res[d][0]);
      check($sformatf("d%0d rsp1_result", d), obs_res1[d], m_res[d][1]);
      check($sformatf("d%0d alu_src1", d), obs_as1[d], (win < 0) ? 32'h0 : req_src1[win]);
      check($sformatf("d%0d alu_src2", d), obs_as2[d], (win < 0) ? 32'h0 : req_src2[win]);
      check($sformatf("d%0d alu_op", d), 32'(obs_aop[d]), (win < 0) ? 32'h0 : 32'(req_op[win]));
      last_win[d] = win;

      if (rst) begin
        m_turn[d] = 0;
        m_rv[d]   = 2'b00;
        m_res[d][0] = 32'h0;
        m_res[d][1] = 32'h0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (win == i) begin
            m_rv[d][i]  = 1'b1;
            m_res[d][i] = alu_fn(req_src1[i], req_src2[i], req_op[i]);
          end else if (rsp_ready[i]) begin
            m_rv[d][i] = 1'b0;
          end
        end
        if (win >= 0) m_turn[d] = 1 - win;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_src1[i]  = $urandom;
      req_src2[i]  = $urandom;
      req_op[i]    = 13'h0004;
      rsp_ready[i] = 1'b1;
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [12:0] op);
    req_valid[i] = 1'b1;
    req_src1[i]  = a;
    req_src2[i]  = b;
    req_op[i]    = op;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [12:0] op_tab [7];
    op_tab = '{13'h0004, 13'h0008, 13'h0010, 13'h0800, 13'h1000, 13'h0001, 13'h0041};
    for (int d = 0; d < 2; d++) begin
      m_turn[d] = 0;
      m_rv[d]   = 2'b00;
      m_res[d][0] = 32'h0;
      m_res[d][1] = 32'h0;
      last_win[d] = -1;
    end

    // Reset with requests asserted: nothing may be granted.
    idle();
    req_valid[0] = 1'b1;
    req_valid[1] = 1'b1;
    rst = 1'b1;
    repeat (3) cycle();
    check("reset rsp_valid", 32'(obs_rv[0]), 32'h0);
    check("reset rsp0_result", obs_res0[0], 32'h0);
    rst = 1'b0;

    // Single add request.
    idle();
    set_req(0, 32'd5, 32'd3, 13'h0004);
    cycle();
    check("single grant", 32'(last_win[0]), 32'd0);
    check("single rsp_valid", 32'(obs_rv[0][0]), 32'd1);
    check("single result", obs_res0[0], 32'd8);
    idle();
    cycle();

    // Round-robin contention vs fixed priority.
    do_reset();
    idle();
    for (int k = 0; k < 4; k++) begin
      set_req(0, $urandom, $urandom, 13'h0004);
      set_req(1, $urandom, $urandom, 13'h0008);
      cycle();
      check($sformatf("rr grant %0d", k), 32'(last_win[0]), 32'(k % 2));
      check($sformatf("fixed grant %0d", k), 32'(last_win[1]), 32'd0);
      check($sformatf("fixed req1_ready %0d", k), 32'(obs_rdy[1][1]), 32'd0);
    end

    // Backpressure on requester 1.
    do_reset();
    idle();
    rsp_ready[1] = 1'b0;
    set_req(1, 32'd1, 32'd3, 13'h0008);
    cycle();
    check("bp first result", obs_res1[0], 32'hFFFF_FFFE);
    set_req(0, 32'd7, 32'd9, 13'h0010);
    cycle();
    check("bp grant while held", 32'(last_win[0]), 32'd0);
    check("bp result held", obs_res1[0], 32'hFFFF_FFFE);
    rsp_ready[1] = 1'b1;
    set_req(1, 32'd10, 32'd4, 13'h0008);
    cycle();
    check("bp drain grant", 32'(last_win[0]), 32'd1);
    check("bp new result", obs_res1[0], 32'd6);
    idle();
    cycle();

    // Back-to-back on requester 0.
    do_reset();
    idle();
    set_req(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 13'h0010);
    cycle();
    check("b2b and valid", 32'(obs_rv[0][0]), 32'd1);
    check("b2b and result", obs_res0[0], 32'h00F0_00F0);
    set_req(0, 32'd1, 32'd31, 13'h1000);
    cycle();
    check("b2b slli valid", 32'(obs_rv[0][0]), 32'd1);
    check("b2b slli result", obs_res0[0], 32'h8000_0000);
    idle();
    cycle();

    // Reset right after a grant discards the response and restores the pointer.
    do_reset();
    idle();
    set_req(0, 32'd2, 32'd2, 13'h0004);
    cycle();
    set_req(1, 32'd2, 32'd2, 13'h0004);
    cycle();
    rst = 1'b1;
    cycle();
    check("mid-rst rsp_valid", 32'(obs_rv[0]), 32'h0);
    check("mid-rst result", obs_res1[0], 32'h0);
    rst = 1'b0;
    set_req(0, $urandom, $urandom, 13'h0004);
    set_req(1, $urandom, $urandom, 13'h0004);
    cycle();
    check("post-rst pointer", 32'(last_win[0]), 32'd0);

    // Randomised traffic with occasional resets and non-one-hot ops.
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(63) == 0);
      for (int i = 0; i < 2; i++) begin
        req_valid[i] = ($urandom_range(3) != 0);
        req_src1[i]  = $urandom;
        req_src2[i]  = $urandom;
        req_op[i]    = op_tab[$urandom_range(6)];
        rsp_ready[i] = ($urandom_range(2) != 0);
      end
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
